// File: rtl/ping_ranger.sv
// PING))) ranger: triggers the sensor on its shared SIG pin, times the echo and publishes
// distance in cm with a one-cycle start strobe. Define PING_RANGER_AVG_EN for a 4-reading average.
module ping_ranger #(
  parameter int CLKS_PER_US     = 100,
  parameter int TRIG_US         = 5,
  parameter int HOLDOFF_US      = 750,
  parameter int RISE_TIMEOUT_US = 1000,
  parameter int ECHO_MAX_US     = 18500,
  parameter int PERIOD_US       = 60000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sig_in,
  output logic       sig_out,
  output logic       sig_oe,
  output logic [6:0] d,
  output logic       start,
  output logic       busy,
  output logic       timeout
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [6:0] sat_inc_cm(input logic [6:0] v);
    return (v == 7'd127) ? v : v + 7'd1;
  endfunction

  localparam int PS_W     = $clog2(CLKS_PER_US + 1);
  localparam int TMAX     = max2(max2(TRIG_US, HOLDOFF_US), max2(RISE_TIMEOUT_US, ECHO_MAX_US));
  localparam int TM_W     = $clog2(TMAX + 1);
  // IDLE and the IDLE->TRIG hop each take one cycle, so GAP releases two cycles early.
  localparam int PRD_CLKS = PERIOD_US * CLKS_PER_US - 2;
  localparam int PRD_W    = $clog2(PRD_CLKS + 1);

  typedef enum logic [2:0] {IDLE, TRIG, HOLDOFF, WAIT_RISE, MEASURE, DONE, GAP} state_t;

  state_t            state, nxt;
  logic              sig_meta_p0, echo_p1;
  logic [PS_W-1:0]   ps;
  logic [TM_W-1:0]   tcnt;
  logic [PRD_W-1:0]  prd;
  logic [5:0]        sub, sub_adv;
  logic [6:0]        cm, cm_adv;
  logic [6:0]        res_d;
  logic              res_to;
  logic              us_tick, trig_end, hold_end, rise_end, echo_end;

  assign us_tick  = (ps == PS_W'(CLKS_PER_US - 1));
  assign trig_end = us_tick && (tcnt == TM_W'(TRIG_US - 1));
  assign hold_end = us_tick && (tcnt == TM_W'(HOLDOFF_US - 1));
  assign rise_end = us_tick && (tcnt == TM_W'(RISE_TIMEOUT_US - 1));
  assign echo_end = us_tick && (tcnt == TM_W'(ECHO_MAX_US - 1));

  assign sig_oe  = (state == TRIG);
  assign sig_out = (state == TRIG);
  assign busy    = (state != IDLE);
  assign start   = (state == DONE);

  // cm/sub cascade: sub divides the us ticks by 58, cm saturates at 127
  always_comb begin
    sub_adv = sub;
    cm_adv  = cm;
    if (us_tick) begin
      if (sub == 6'd57) begin
        sub_adv = 6'd0;
        cm_adv  = sat_inc_cm(cm);
      end else begin
        sub_adv = sub + 6'd1;
      end
    end
  end

  always_comb begin
    nxt    = state;
    res_d  = 7'd127;
    res_to = 1'b1;
    case (state)
      IDLE:      if (en) nxt = TRIG;
      TRIG:      if (trig_end) nxt = HOLDOFF;
      HOLDOFF:   if (hold_end) nxt = WAIT_RISE;
      WAIT_RISE: begin
        if (echo_p1)       nxt = MEASURE;
        else if (rise_end) nxt = DONE;
      end
      MEASURE: begin
        // The rise was seen one cycle before MEASURE, so a tick on the falling cycle still counts.
        if (!echo_p1) begin
          nxt    = DONE;
          res_d  = cm_adv;
          res_to = 1'b0;
        end else if (echo_end) begin
          nxt = DONE;
        end
      end
      DONE:      nxt = GAP;
      GAP:       if (prd >= PRD_W'(PRD_CLKS)) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

`ifdef PING_RANGER_AVG_EN
  logic [6:0] hist [3];
  logic       hist_vld;
  logic [8:0] avg_sum;

  always_comb begin
    avg_sum = {res_d, 2'b00};
    if (hist_vld)
      avg_sum = {2'b00, res_d} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_vld <= 1'b0;
      for (int i = 0; i < 3; i++) hist[i] <= '0;
    end else if (nxt == DONE && !res_to) begin
      hist_vld <= 1'b1;
      hist[0]  <= res_d;
      hist[1]  <= hist_vld ? hist[0] : res_d;
      hist[2]  <= hist_vld ? hist[1] : res_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sig_meta_p0 <= 1'b0;
      echo_p1     <= 1'b0;
      ps          <= '0;
      tcnt        <= '0;
      prd         <= '0;
      sub         <= '0;
      cm          <= '0;
      d           <= '0;
      timeout     <= 1'b0;
    end else begin
      // pad synchronizer: p0 may go metastable, p1 feeds all echo decisions
      sig_meta_p0 <= sig_in;
      echo_p1     <= sig_meta_p0;
      state       <= nxt;
      if (nxt != state) begin
        ps   <= '0;
        tcnt <= '0;
      end else if (us_tick) begin
        ps   <= '0;
        tcnt <= tcnt + TM_W'(1);
      end else begin
        ps <= ps + PS_W'(1);
      end
      if (state == IDLE && nxt == TRIG)  prd <= '0;
      else if (prd != PRD_W'(PRD_CLKS))  prd <= prd + PRD_W'(1);
      if (state == WAIT_RISE) begin
        sub <= '0;
        cm  <= '0;
      end else if (state == MEASURE && echo_p1) begin
        sub <= sub_adv;
        cm  <= cm_adv;
      end
      if (nxt == DONE) begin
        timeout <= res_to;
`ifdef PING_RANGER_AVG_EN
        if (!res_to) d <= avg_sum[8:2];
`else
        d <= res_d;
`endif
      end
    end
  end

endmodule
